sequential_left_shifter: RTL

Multi-cycle 16-bit left shifter, the counterpart to the ALU's combinational arithmetic right shift. It shifts one bit position per clock under a start/busy/done handshake. It reports signed overflow whenever any shifted-out bit or intermediate MSB differs from the operand's original sign. It sits beside the combinational ALU datapath and serves shift-left opcodes, where a small iterative unit is preferred to a second 16:1 mux bank.

---
 rtl/alu_pkg.sv | 13 +
 rtl/sequential_left_shifter.sv | 94 +++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants and the iterative shifter state encoding.
package alu_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned SHW   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shift_state_t;

endpackage

// File: rtl/sequential_left_shifter.sv
// Multi-cycle left shifter: one bit per clock, start/busy/done handshake,
// sticky signed-overflow flag when any bit shifted through the MSB differs from the sign.
module sequential_left_shifter
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Y,
    output logic             overflow
);

    shift_state_t     state;
    shift_state_t     state_next;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] r_next;
    logic [SHW-1:0]   cnt;
    logic [SHW-1:0]   cnt_next;
    logic             sign;
    logic             sign_next;
    logic             overflow_next;

    // Only the low SHW bits of B carry a shift amount.
    logic unused_b_hi;
    assign unused_b_hi = ^B[WIDTH-1:SHW];

    // Result is the working register itself; consumers sample on done.
    assign Y = r;

    // Next-state and datapath update.
    always_comb begin
        state_next    = state;
        r_next        = r;
        cnt_next      = cnt;
        sign_next     = sign;
        overflow_next = overflow;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    r_next        = A;
                    sign_next     = A[WIDTH-1];
                    cnt_next      = B[SHW-1:0];
                    overflow_next = 1'b0;
                    state_next    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt == SHW'(0)) begin
                    state_next = ST_DONE;
                end else begin
                    r_next   = {r[WIDTH-2:0], 1'b0};
                    cnt_next = cnt - SHW'(1);
                    // The bit about to become the MSB must match the original sign.
                    if (r[WIDTH-2] != sign) begin
                        overflow_next = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers; busy/done are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            r        <= '0;
            cnt      <= '0;
            sign     <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            r        <= r_next;
            cnt      <= cnt_next;
            sign     <= sign_next;
            overflow <= overflow_next;
            busy     <= (state_next == ST_SHIFT);
            done     <= (state_next == ST_DONE);
        end
    end

endmodule
